// File: rtl/itlb_refill_ctrl.sv
// ITLB miss/refill controller: takes an ITLB miss, walks it through the PTW and writes the leaf PTE
// into a victim entry. Define ITLB_FIRST_INVALID_EN to prefer the lowest invalid entry over round-robin.
module itlb_refill_ctrl #(
  parameter int ENTRY_NUM = 31,
  parameter int PTE_W     = 64,
  parameter int VPN_W     = 27
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 miss_valid_i,
  input  logic [VPN_W-1:0]     miss_vpn_i,
  output logic                 miss_ready_o,
  input  logic                 flush_i,
  output logic                 ptw_req_valid_o,
  output logic [VPN_W-1:0]     ptw_req_vpn_o,
  input  logic                 ptw_req_ready_i,
  input  logic                 ptw_resp_valid_i,
  input  logic [PTE_W-1:0]     ptw_resp_pte_i,
  input  logic                 ptw_resp_fault_i,
  input  logic [ENTRY_NUM-1:0] valid_vec_i,
  output logic [ENTRY_NUM-1:0] wr_en_o,
  output logic [PTE_W-1:0]     pte_wr_o,
  output logic [VPN_W-1:0]     tag_vpn_o,
  output logic                 refill_done_o,
  output logic                 fault_o
);

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FILL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VPN_W-1:0]   r_vpn;
  logic [PTE_W-1:0]   r_pte;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_fault;

  logic               w_latch_vpn;
  logic               w_latch_pte;
  logic               w_fault_set;
  logic               w_fill;
  logic               w_use_ptr;
  logic [PTR_W-1:0]   w_victim;
  logic               w_ptr_adv;

`ifdef ITLB_FIRST_INVALID_EN
  // Returns {found, index} of the lowest-index zero bit.
  function automatic logic [PTR_W:0] first_zero(input logic [ENTRY_NUM-1:0] vec);
    logic [PTR_W:0] res;
    res = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        res = {1'b1, PTR_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [PTR_W:0] w_first_inv;
  assign w_first_inv = first_zero(valid_vec_i);

  // Victim selection: first invalid entry, else the round-robin pointer.
  always_comb begin
    w_use_ptr = 1'b1;
    w_victim  = r_ptr;
    if (w_first_inv[PTR_W]) begin
      w_use_ptr = 1'b0;
      w_victim  = w_first_inv[PTR_W-1:0];
    end else begin
      w_use_ptr = 1'b1;
      w_victim  = r_ptr;
    end
  end
`else
  logic w_unused_vec;
  assign w_unused_vec = ^valid_vec_i;
  assign w_use_ptr    = 1'b1;
  assign w_victim     = r_ptr;
`endif

  assign w_ptr_adv = w_fill & w_use_ptr;

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_latch_vpn = 1'b0;
    w_latch_pte = 1'b0;
    w_fault_set = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (miss_valid_i && !flush_i) begin
          w_latch_vpn = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (flush_i) begin
          w_state_nxt = ptw_req_ready_i ? S_DRAIN : S_IDLE;
        end else if (ptw_req_ready_i) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (ptw_resp_valid_i) begin
          if (flush_i) begin
            w_state_nxt = S_IDLE;
          end else if (ptw_resp_fault_i) begin
            w_fault_set = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_latch_pte = 1'b1;
            w_state_nxt = S_FILL;
          end
        end else if (flush_i) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_FILL: begin
        // A flush here kills the write and leaves the pointer alone.
        w_fill      = !flush_i;
        w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (ptw_resp_valid_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched miss/PTE data, fault pulse and victim pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_vpn   <= '0;
      r_pte   <= '0;
      r_ptr   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_set;
      if (w_latch_vpn) begin
        r_vpn <= miss_vpn_i;
      end
      if (w_latch_pte) begin
        r_pte <= ptw_resp_pte_i;
      end
      if (w_ptr_adv) begin
        r_ptr <= (r_ptr == PTR_W'(ENTRY_NUM - 1)) ? '0 : r_ptr + PTR_W'(1);
      end
    end
  end

  assign miss_ready_o    = (r_state == S_IDLE);
  assign ptw_req_valid_o = (r_state == S_REQ);
  assign ptw_req_vpn_o   = r_vpn;
  assign wr_en_o         = w_fill ? (ENTRY_NUM'(1'b1) << w_victim) : '0;
  assign pte_wr_o        = w_fill ? r_pte : '0;
  assign tag_vpn_o       = w_fill ? r_vpn : '0;
  assign refill_done_o   = w_fill;
  assign fault_o         = r_fault;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Self-checking bench for itlb_refill_ctrl: directed transactions, a victim/write scoreboard model
// and per-cycle output checks. Expectations follow ITLB_FIRST_INVALID_EN when it is defined.
module tb_itlb_refill_ctrl;
  localparam int EN = 31;
  localparam int PW = 64;
  localparam int VW = 27;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          miss_valid_i = 1'b0;
  logic [VW-1:0] miss_vpn_i = '0;
  logic          miss_ready_o;
  logic          flush_i = 1'b0;
  logic          ptw_req_valid_o;
  logic [VW-1:0] ptw_req_vpn_o;
  logic          ptw_req_ready_i = 1'b0;
  logic          ptw_resp_valid_i = 1'b0;
  logic [PW-1:0] ptw_resp_pte_i = '0;
  logic          ptw_resp_fault_i = 1'b0;
  logic [EN-1:0] valid_vec_i = '1;
  logic [EN-1:0] wr_en_o;
  logic [PW-1:0] pte_wr_o;
  logic [VW-1:0] tag_vpn_o;
  logic          refill_done_o;
  logic          fault_o;

  itlb_refill_ctrl #(.ENTRY_NUM(EN), .PTE_W(PW), .VPN_W(VW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .miss_valid_i(miss_valid_i), .miss_vpn_i(miss_vpn_i), .miss_ready_o(miss_ready_o),
    .flush_i(flush_i),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_pte_i(ptw_resp_pte_i), .ptw_resp_fault_i(ptw_resp_fault_i),
    .valid_vec_i(valid_vec_i), .wr_en_o(wr_en_o), .pte_wr_o(pte_wr_o), .tag_vpn_o(tag_vpn_o),
    .refill_done_o(refill_done_o), .fault_o(fault_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    int            idx;
    logic [PW-1:0] pte;
    logic [VW-1:0] vpn;
  } wr_t;

  int            total = 0;
  int            bad = 0;
  int            m_ptr = 0;
  bit            started = 1'b0;
  bit            exp_fault_cyc = 1'b0;
  wr_t           exp_q[$];
  wr_t           cmp_e;
  logic [EN-1:0] cap_wr;
  logic [PW-1:0] cap_pte;
  logic [VW-1:0] cap_tag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Reference victim choice: lowest invalid entry (feature on) else a modulo-EN round-robin counter.
  function automatic int model_victim(input logic [EN-1:0] vv);
    int v;
`ifdef ITLB_FIRST_INVALID_EN
    for (int i = 0; i < EN; i++) if (!vv[i]) return i;
`endif
    v = m_ptr;
    m_ptr = (m_ptr + 1) % EN;
    return v;
  endfunction

  // Per-cycle output checks against the scoreboard.
  always @(negedge clk_i) begin
    if (started) begin
      if (!rstn_i) begin
        chk("rst_miss_ready", 64'(miss_ready_o), 64'd1);
        chk("rst_outputs", 64'({ptw_req_valid_o, refill_done_o, fault_o, |wr_en_o, |pte_wr_o,
                                |tag_vpn_o, |ptw_req_vpn_o}), 64'd0);
      end else begin
        chk("wr_en_onehot0", 64'($onehot0(wr_en_o)), 64'd1);
        if (wr_en_o != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(wr_en_o), 64'd0);
          end else begin
            cmp_e = exp_q.pop_front();
            chk("victim", 64'(wr_en_o), 64'd1 << cmp_e.idx);
            chk("pte_wr", pte_wr_o, cmp_e.pte);
            chk("tag_vpn", 64'(tag_vpn_o), 64'(cmp_e.vpn));
            chk("refill_done", 64'(refill_done_o), 64'd1);
          end
        end else begin
          chk("no_write_gating", 64'({refill_done_o, |pte_wr_o, |tag_vpn_o}), 64'd0);
        end
        chk("fault_pulse", 64'(fault_o), 64'(exp_fault_cyc));
      end
    end
  end

  task automatic reset_dut;
    rstn_i = 1'b0;
    tick;
    tick;
    m_ptr = 0;
    rstn_i = 1'b1;
    tick;
  endtask

  task automatic accept(input logic [VW-1:0] vpn);
    chk("accept_ready", 64'(miss_ready_o), 64'd1);
    miss_valid_i = 1'b1;
    miss_vpn_i   = vpn;
    tick;
    miss_valid_i = 1'b0;
    miss_vpn_i   = '0;
  endtask

  // One miss from accept to return to IDLE; capture the FILL-cycle write.
  task automatic miss_txn(input logic [VW-1:0] vpn, input logic [PW-1:0] pte, input logic flt,
                          input int rdy_dly, input int rsp_dly, input logic [EN-1:0] vv,
                          input logic flush_fill);
    int idx;
    valid_vec_i = vv;
    accept(vpn);
    for (int k = 0; k < rdy_dly; k++) begin
      chk("req_hold_valid", 64'(ptw_req_valid_o), 64'd1);
      chk("req_hold_vpn", 64'(ptw_req_vpn_o), 64'(vpn));
      tick;
    end
    chk("req_valid", 64'(ptw_req_valid_o), 64'd1);
    chk("req_vpn", 64'(ptw_req_vpn_o), 64'(vpn));
    ptw_req_ready_i = 1'b1;
    tick;
    ptw_req_ready_i = 1'b0;
    chk("req_dropped", 64'(ptw_req_valid_o), 64'd0);
    repeat (rsp_dly) tick;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_pte_i   = pte;
    ptw_resp_fault_i = flt;
    if (!flt && !flush_fill) begin
      idx = model_victim(vv);
      exp_q.push_back('{idx, pte, vpn});
    end
    tick;
    ptw_resp_valid_i = 1'b0;
    ptw_resp_pte_i   = '0;
    ptw_resp_fault_i = 1'b0;
    if (flt) begin
      exp_fault_cyc = 1'b1;
      chk("fault_cycle_ready", 64'(miss_ready_o), 64'd1);
      tick;
      exp_fault_cyc = 1'b0;
      chk("after_fault_ready", 64'(miss_ready_o), 64'd1);
    end else begin
      flush_i = flush_fill;
      #1;
      cap_wr  = wr_en_o;
      cap_pte = pte_wr_o;
      cap_tag = tag_vpn_o;
      chk("fill_done", 64'(refill_done_o), 64'(!flush_fill));
      tick;
      flush_i = 1'b0;
      chk("done_cleared", 64'(refill_done_o), 64'd0);
      chk("back_idle", 64'(miss_ready_o), 64'd1);
    end
  endtask

  initial begin
    tick;
    started = 1'b1;
    tick;
    chk("reset_ready", 64'(miss_ready_o), 64'd1);
    chk("reset_wr_en", 64'(wr_en_o), 64'd0);
    rstn_i = 1'b1;
    tick;

    // Basic refill, response two cycles into WAIT.
    miss_txn(27'h123, 64'hDEAD_0001, 1'b0, 0, 2, '1, 1'b0);
    chk("t1_wr_en", 64'(cap_wr), 64'h1);
    chk("t1_pte", cap_pte, 64'hDEAD_0001);
    chk("t1_tag", 64'(cap_tag), 64'h123);
    // Zero-wait PTW: write lands exactly three cycles after accept.
    miss_txn(27'h0AB, 64'h0000_1234_5678_9ABC, 1'b0, 0, 0, '1, 1'b0);
    chk("t2_wr_en", 64'(cap_wr), 64'h2);
    // Request held through five cycles of backpressure.
    miss_txn(27'h7FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5, 1, '1, 1'b0);
    chk("t3_wr_en", 64'(cap_wr), 64'h4);
    chk("t3_tag", 64'(cap_tag), 64'h7FF_FFFF);
    // Faulting walk.
    miss_txn(27'h055, 64'h0BAD, 1'b1, 0, 1, '1, 1'b0);

    // Flush in WAIT, response later lands in DRAIN and is discarded.
    accept(27'h0AA);
    ptw_req_ready_i = 1'b1;
    tick;
    ptw_req_ready_i = 1'b0;
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    chk("drain_not_ready", 64'(miss_ready_o), 64'd0);
    tick;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_pte_i   = 64'hCAFE;
    tick;
    ptw_resp_valid_i = 1'b0;
    ptw_resp_pte_i   = '0;
    chk("drain_to_idle", 64'(miss_ready_o), 64'd1);
    miss_txn(27'h0BB, 64'h0000_0000_0000_BEEF, 1'b0, 0, 0, '1, 1'b0);
    chk("after_drain_wr_en", 64'(cap_wr), 64'h8);

    // Flush in REQ before handshake: straight back to IDLE.
    accept(27'h011);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    chk("req_flush_idle", 64'(miss_ready_o), 64'd1);
    chk("req_flush_noreq", 64'(ptw_req_valid_o), 64'd0);

    // Flush together with ready: DRAIN swallows the next (faulting) response.
    accept(27'h022);
    ptw_req_ready_i = 1'b1;
    flush_i = 1'b1;
    tick;
    ptw_req_ready_i = 1'b0;
    flush_i = 1'b0;
    chk("req_rdy_flush_drain", 64'(miss_ready_o), 64'd0);
    chk("req_rdy_flush_noreq", 64'(ptw_req_valid_o), 64'd0);
    tick;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_fault_i = 1'b1;
    tick;
    ptw_resp_valid_i = 1'b0;
    ptw_resp_fault_i = 1'b0;
    chk("drain_fault_idle", 64'(miss_ready_o), 64'd1);
    tick;

    // Flush in WAIT with the response in the same cycle: directly IDLE.
    accept(27'h033);
    ptw_req_ready_i = 1'b1;
    tick;
    ptw_req_ready_i = 1'b0;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_pte_i   = 64'h5555;
    flush_i = 1'b1;
    tick;
    ptw_resp_valid_i = 1'b0;
    ptw_resp_pte_i   = '0;
    flush_i = 1'b0;
    chk("wait_flush_resp_idle", 64'(miss_ready_o), 64'd1);

    // Flush in IDLE blocks the miss.
    miss_valid_i = 1'b1;
    miss_vpn_i   = 27'h044;
    flush_i = 1'b1;
    tick;
    miss_valid_i = 1'b0;
    flush_i = 1'b0;
    chk("idle_flush_ready", 64'(miss_ready_o), 64'd1);
    chk("idle_flush_noreq", 64'(ptw_req_valid_o), 64'd0);

    // Flush in FILL: no write, pointer stays.
    miss_txn(27'h066, 64'h6666, 1'b0, 0, 0, '1, 1'b1);
    chk("fill_flush_wr_en", 64'(cap_wr), 64'd0);
    miss_txn(27'h077, 64'h7777, 1'b0, 0, 0, '1, 1'b0);
    chk("after_fill_flush_wr_en", 64'(cap_wr), 64'h10);

    // Reset while in WAIT; a later response must be ignored.
    accept(27'h088);
    ptw_req_ready_i = 1'b1;
    tick;
    ptw_req_ready_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    chk("async_rst_ready", 64'(miss_ready_o), 64'd1);
    chk("async_rst_vpn", 64'(ptw_req_vpn_o), 64'd0);
    m_ptr = 0;
    tick;
    rstn_i = 1'b1;
    tick;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_pte_i   = 64'h8888;
    tick;
    ptw_resp_valid_i = 1'b0;
    ptw_resp_pte_i   = '0;
    chk("post_rst_ready", 64'(miss_ready_o), 64'd1);
    miss_txn(27'h099, 64'h9999, 1'b0, 0, 0, '1, 1'b0);
    chk("post_rst_wr_en", 64'(cap_wr), 64'h1);

    // 32 back-to-back misses with every entry valid: pointer wraps after entry 30.
    reset_dut;
    for (int i = 0; i < 32; i++) begin
      miss_txn(VW'(i + 256), 64'h1000 + 64'(i), 1'b0, 0, 0, '1, 1'b0);
      if (i == 30) chk("rr_last_entry", 64'(cap_wr), 64'h4000_0000);
      if (i == 31) chk("rr_wrap", 64'(cap_wr), 64'h1);
    end

    // Victim choice with one invalid entry, then all valid again.
    reset_dut;
    miss_txn(27'h100, 64'hA0, 1'b0, 0, 0, '1, 1'b0);
    chk("sel_a", 64'(cap_wr), 64'h1);
    miss_txn(27'h101, 64'hA1, 1'b0, 0, 0, ~(EN'(1) << 7), 1'b0);
`ifdef ITLB_FIRST_INVALID_EN
    chk("sel_b_first_invalid", 64'(cap_wr), 64'h80);
`else
    chk("sel_b_round_robin", 64'(cap_wr), 64'h2);
`endif
    miss_txn(27'h102, 64'hA2, 1'b0, 0, 0, '1, 1'b0);
`ifdef ITLB_FIRST_INVALID_EN
    chk("sel_c_pointer_kept", 64'(cap_wr), 64'h2);
`else
    chk("sel_c_round_robin", 64'(cap_wr), 64'h4);
`endif

    tick;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
